// File: rtl/logic_unit_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_bist_ctrl
// Description : Built-in self-test controller for a 4-function logic unit
//               (AND / OR / XOR / XNOR selected by a 2-bit Sel). On start it
//               walks every {Sel, A, B} vector, holds each one for
//               SETTLE_CYCLES, samples the unit's output for one cycle,
//               compares it with an internal golden model, counts mismatches
//               (saturating) and captures the first failing vector.
// Ports       : clk, rst_n (async, active-low)
//               start, abort            - sweep control
//               dut_out                 - output of the logic unit under test
//               A, B, Sel               - registered stimulus to the unit
//               busy, done, pass        - sweep status
//               err_count               - saturating mismatch count
//               first_fail_*            - capture of the first mismatch
// Revision    : 1.0 - initial release
// ============================================================================
module logic_unit_bist_ctrl #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] dut_out,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [1:0]       Sel,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_fail_valid,
    output logic [WIDTH-1:0] first_fail_A,
    output logic [WIDTH-1:0] first_fail_B,
    output logic [1:0]       first_fail_Sel,
    output logic [WIDTH-1:0] first_fail_got
);

    localparam int IDX_W = 2 * WIDTH + 2;
    localparam int SC_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [SC_W-1:0]  c_SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] c_IDX_LAST    = '1;
    localparam logic [ERR_W-1:0] c_ERR_MAX     = '1;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETTLE = 2'd1;
    localparam logic [1:0] c_ST_CHECK  = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [SC_W-1:0]  r_settle_cnt;
    logic             r_pass;
    logic [ERR_W-1:0] r_err_count;
    logic             r_ff_valid;
    logic [WIDTH-1:0] r_ff_a;
    logic [WIDTH-1:0] r_ff_b;
    logic [1:0]       r_ff_sel;
    logic [WIDTH-1:0] r_ff_got;

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [1:0]       w_sel;
    logic [WIDTH-1:0] w_golden;
    logic             w_mismatch;

    // The vector index is laid out as {Sel, A, B}, so a plain increment walks
    // B innermost and Sel outermost, and the stimulus is a direct slice of it.
    assign w_sel = r_idx[IDX_W-1 -: 2];
    assign w_a   = r_idx[2*WIDTH-1 -: WIDTH];
    assign w_b   = r_idx[WIDTH-1:0];

    always_comb begin
        w_golden = '0;
        case (w_sel)
            2'b00:   w_golden = w_a & w_b;
            2'b01:   w_golden = w_a | w_b;
            2'b10:   w_golden = w_a ^ w_b;
            default: w_golden = ~(w_a ^ w_b);
        endcase
    end

    assign w_mismatch = (dut_out != w_golden);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_idx        <= '0;
            r_settle_cnt <= '0;
            r_pass       <= 1'b0;
            r_err_count  <= '0;
            r_ff_valid   <= 1'b0;
            r_ff_a       <= '0;
            r_ff_b       <= '0;
            r_ff_sel     <= '0;
            r_ff_got     <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (abort) begin
                        // Leaving DONE drops the result flags; error capture
                        // stays readable until the next start.
                        r_state      <= c_ST_IDLE;
                        r_idx        <= '0;
                        r_settle_cnt <= '0;
                        r_pass       <= 1'b0;
                    end else if (start) begin
                        r_state      <= c_ST_SETTLE;
                        r_idx        <= '0;
                        r_settle_cnt <= '0;
                        r_pass       <= 1'b0;
                        r_err_count  <= '0;
                        r_ff_valid   <= 1'b0;
                        r_ff_a       <= '0;
                        r_ff_b       <= '0;
                        r_ff_sel     <= '0;
                        r_ff_got     <= '0;
                    end
                end

                c_ST_SETTLE: begin
                    if (abort) begin
                        r_state      <= c_ST_IDLE;
                        r_idx        <= '0;
                        r_settle_cnt <= '0;
                        r_pass       <= 1'b0;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                        if (r_settle_cnt == c_SETTLE_LAST) begin
                            r_state <= c_ST_CHECK;
                        end
                    end
                end

                c_ST_CHECK: begin
                    if (abort) begin
                        // The vector being checked is discarded, not scored.
                        r_state      <= c_ST_IDLE;
                        r_idx        <= '0;
                        r_settle_cnt <= '0;
                        r_pass       <= 1'b0;
                    end else begin
                        if (w_mismatch) begin
                            if (r_err_count != c_ERR_MAX) begin
                                r_err_count <= r_err_count + 1'b1;
                            end
                            if (!r_ff_valid) begin
                                r_ff_valid <= 1'b1;
                                r_ff_a     <= w_a;
                                r_ff_b     <= w_b;
                                r_ff_sel   <= w_sel;
                                r_ff_got   <= dut_out;
                            end
                        end
                        if (r_idx != c_IDX_LAST) begin
                            r_idx        <= r_idx + 1'b1;
                            r_settle_cnt <= '0;
                            r_state      <= c_ST_SETTLE;
                        end else begin
                            r_state <= c_ST_DONE;
                            // Fold in the last vector's result, which is not
                            // yet visible in the registered error state.
                            r_pass  <= ~(r_ff_valid | w_mismatch);
                        end
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign A                = w_a;
    assign B                = w_b;
    assign Sel              = w_sel;
    assign busy             = (r_state == c_ST_SETTLE) || (r_state == c_ST_CHECK);
    assign done             = (r_state == c_ST_DONE);
    assign pass             = r_pass;
    assign err_count        = r_err_count;
    assign first_fail_valid = r_ff_valid;
    assign first_fail_A     = r_ff_a;
    assign first_fail_B     = r_ff_b;
    assign first_fail_Sel   = r_ff_sel;
    assign first_fail_got   = r_ff_got;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_unit_bist_ctrl
// Description : Self-checking bench for logic_unit_bist_ctrl. A model of the
//               logic unit (correct, XNOR bit0 stuck, tied to zero, or with
//               random flipped vectors) drives dut_out; expected sweep
//               results are computed by enumerating the vector list.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_unit_bist_ctrl;

    localparam int W     = 4;
    localparam int SC    = 2;
    localparam int EW    = 8;
    localparam int NV    = 1024;
    localparam int SWEEP = NV * (SC + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [W-1:0]  dut_out;
    logic [W-1:0]  A, B;
    logic [1:0]    Sel;
    logic          busy, done, pass;
    logic [EW-1:0] err_count;
    logic          ff_valid;
    logic [W-1:0]  ff_a, ff_b, ff_got;
    logic [1:0]    ff_sel;

    int       mode = 0;
    logic [3:0] flip_mask = 4'h1;
    bit       flip_en [NV];
    int       n_checks = 0;
    int       n_pass = 0;

    logic_unit_bist_ctrl #(.WIDTH(W), .SETTLE_CYCLES(SC), .ERR_W(EW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .dut_out(dut_out), .A(A), .B(B), .Sel(Sel),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_fail_valid(ff_valid), .first_fail_A(ff_a), .first_fail_B(ff_b),
        .first_fail_Sel(ff_sel), .first_fail_got(ff_got)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] golden(input logic [1:0] s, input logic [3:0] a, input logic [3:0] b);
        case (s)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a ^ b);
        endcase
    endfunction

    // Logic unit under test, with selectable faults.
    function automatic logic [3:0] model_out(input int m, input logic [1:0] s, input logic [3:0] a,
                                             input logic [3:0] b, input bit fl, input logic [3:0] mask);
        case (m)
            1:       return (s == 2'd3) ? (golden(s, a, b) & 4'b1110) : golden(s, a, b);
            2:       return 4'b0000;
            3:       return fl ? (golden(s, a, b) ^ mask) : golden(s, a, b);
            default: return golden(s, a, b);
        endcase
    endfunction

    always_comb dut_out = model_out(mode, Sel, A, B, flip_en[{Sel, A, B}], flip_mask);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Expected error state after the first n vectors of a sweep have been scored.
    task automatic predict(input int n, output logic [7:0] e, output logic fv, output logic [3:0] fa,
                           output logic [3:0] fb, output logic [1:0] fs, output logic [3:0] fg);
        e = 0; fv = 0; fa = 0; fb = 0; fs = 0; fg = 0;
        for (int i = 0; i < n; i++) begin
            logic [9:0] v;
            logic [3:0] o;
            v = 10'(i);
            o = model_out(mode, v[9:8], v[7:4], v[3:0], flip_en[i], flip_mask);
            if (o !== golden(v[9:8], v[7:4], v[3:0])) begin
                if (e != 8'hFF) e++;
                if (!fv) begin
                    fv = 1; fs = v[9:8]; fa = v[7:4]; fb = v[3:0]; fg = o;
                end
            end
        end
    endtask

    task automatic check_errs(input string tag, input int n);
        logic [7:0] e;
        logic fv;
        logic [3:0] fa, fb, fg;
        logic [1:0] fs;
        predict(n, e, fv, fa, fb, fs, fg);
        check({tag, ".err_count"}, 32'(err_count), 32'(e));
        check({tag, ".ff_valid"}, 32'(ff_valid), 32'(fv));
        check({tag, ".ff_A"}, 32'(ff_a), 32'(fa));
        check({tag, ".ff_B"}, 32'(ff_b), 32'(fb));
        check({tag, ".ff_Sel"}, 32'(ff_sel), 32'(fs));
        check({tag, ".ff_got"}, 32'(ff_got), 32'(fg));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".done"}, 32'(done), 32'd0);
        check({tag, ".pass"}, 32'(pass), 32'd0);
        check({tag, ".vec"}, 32'({Sel, A, B}), 32'd0);
    endtask

    // Starts a sweep (caller positioned #1 after an edge) and follows it to done.
    task automatic run_sweep(input string tag, input bit keep_start);
        int cycles, k, busy_bad;
        logic [7:0] e;
        logic fv;
        logic [3:0] fa, fb, fg;
        logic [1:0] fs;
        repeat ($urandom_range(0, 4)) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        if (!keep_start) start = 1'b0;
        cycles   = 0;
        busy_bad = 0;
        k        = $urandom_range(0, SWEEP - 1);
        while (!done && cycles < SWEEP + 200) begin
            if (!busy) busy_bad++;
            if (cycles == k) check({tag, ".mid_vec"}, 32'({Sel, A, B}), 32'(k / (SC + 1)));
            @(posedge clk); #1;
            cycles++;
        end
        check({tag, ".cycles_to_done"}, 32'(cycles), 32'(SWEEP));
        check({tag, ".busy_cycles_low"}, 32'(busy_bad), 32'd0);
        check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".last_vec"}, 32'({Sel, A, B}), 32'(NV - 1));
        predict(NV, e, fv, fa, fb, fs, fg);
        check({tag, ".pass"}, 32'(pass), 32'(!fv));
        check_errs(tag, NV);
    endtask

    initial begin
        for (int i = 0; i < NV; i++) flip_en[i] = 1'b0;

        // Reset state
        #2;
        check_idle_outputs("reset");
        check("reset.err_count", 32'(err_count), 32'd0);
        check("reset.ff_valid", 32'(ff_valid), 32'd0);
        check("reset.ff_got", 32'(ff_got), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // abort in IDLE is a no-op; start+abort in IDLE stays idle
        abort = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        check_idle_outputs("idle_abort");

        // 1: correct unit
        mode = 0;
        run_sweep("clean", 1'b0);

        // abort in DONE clears done/pass
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check_idle_outputs("done_abort");

        // 2: XNOR bit0 stuck at 0
        mode = 1;
        run_sweep("xnor_stuck", 1'b0);

        // 3: output tied low, counter saturates
        mode = 2;
        run_sweep("tied0", 1'b0);

        // 4: abort 100 cycles after start keeps the partial error capture
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check_idle_outputs("abort");
        check_errs("abort", 100 / (SC + 1));
        mode = 0;
        run_sweep("after_abort", 1'b0);

        // 5: asynchronous reset mid-sweep, between edges
        mode = 2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (500) @(posedge clk);
        #1;
        check_errs("pre_reset", 500 / (SC + 1));
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        check("async_reset.err_count", 32'(err_count), 32'd0);
        check("async_reset.ff_valid", 32'(ff_valid), 32'd0);
        check("async_reset.ff_A", 32'(ff_a), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        mode = 0;
        run_sweep("after_reset", 1'b0);

        // Randomised faults on random vectors
        for (int r = 0; r < 2; r++) begin
            mode = 3;
            flip_mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < NV; i++) flip_en[i] = ($urandom_range(0, 47) == 0);
            run_sweep("random_fault", 1'b0);
        end

        // 6: start held high restarts right after DONE with errors cleared
        mode = 2;
        run_sweep("held_start", 1'b1);
        @(posedge clk); #1;
        check("restart.busy", 32'(busy), 32'd1);
        check("restart.done", 32'(done), 32'd0);
        check("restart.err_count", 32'(err_count), 32'd0);
        check("restart.ff_valid", 32'(ff_valid), 32'd0);
        check("restart.vec", 32'({Sel, A, B}), 32'd0);
        start = 1'b0;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check_idle_outputs("final_abort");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/logic_unit_bist_ctrl.md
Name: logic_unit_bist_ctrl

Overview:
- Sequential stimulus/response controller for the 4-function logic unit (AND / OR / XOR / XNOR, 2-bit select).
- On a start pulse it drives every {Sel, A, B} combination into the logic unit and samples the unit's Out.
- It compares Out against an internal golden model, counts mismatches, captures the first failure, and reports pass/fail.
- Sits beside the logic unit as its built-in self-test partner: it drives the unit's inputs and receives its output.

Parameters:
- WIDTH, 4, operand width of A, B, Out.
- SETTLE_CYCLES, 2, cycles each vector is held before sampling; legal range is ≥1.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a sweep; sampled in IDLE or DONE only.
- abort  in  1  terminate a sweep in progress.
- dut_out  in  WIDTH  Out of the logic unit under test.
- A  out  WIDTH  operand A to the logic unit (registered).
- B  out  WIDTH  operand B to the logic unit (registered).
- Sel  out  2  function select to the logic unit (registered).
- busy  out  1  sweep in progress.
- done  out  1  sweep completed; held until the next start.
- pass  out  1  done and zero errors.
- err_count  out  ERR_W  mismatch count; saturates at all-ones.
- first_fail_valid  out  1  at least one mismatch captured.
- first_fail_A  out  WIDTH  A of the first mismatch.
- first_fail_B  out  WIDTH  B of the first mismatch.
- first_fail_Sel  out  2  Sel of the first mismatch.
- first_fail_got  out  WIDTH  dut_out value at the first mismatch.

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE.
  - A, B, Sel, busy, done, pass, err_count, all first_fail_* are 0.
  - Settle counter and vector index are 0.
  - Takes effect immediately, including mid-sweep.
- Golden model, combinational from the held vector:
  - Sel=00: A&B
  - Sel=01: A|B
  - Sel=10: A^B
  - Sel=11: ~(A^B)
  - All results are WIDTH bits.
- Vector index is {Sel,A,B}, 2+2*WIDTH bits.
  - Order: Sel outermost, then A, then B innermost, each counting up from 0.
  - N = 2^(2*WIDTH+2) vectors; N = 1024 at defaults.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE, or DONE, with start=1 and abort=0, on a clock edge:
  - Move to SETTLE.
  - Index, A, B, Sel, settle counter, err_count and first_fail_* clear to 0.
  - done and pass clear; busy=1.
- SETTLE:
  - Settle counter increments each cycle.
  - When the counter equals SETTLE_CYCLES-1, go to CHECK.
- CHECK (exactly one cycle):
  - Compare dut_out against the golden model.
  - On mismatch, increment err_count unless it is all-ones.
  - On a mismatch with first_fail_valid=0, capture A/B/Sel/dut_out and set first_fail_valid.
  - If index is not N-1: index+1, load the new A/B/Sel, clear the settle counter, go to SETTLE.
  - If index is N-1: go to DONE, busy=0, done=1, pass=(final err_count==0). pass must include a mismatch on the last vector.
- Timing:
  - Per-vector cost is SETTLE_CYCLES+1 cycles.
  - done rises N*(SETTLE_CYCLES+1) rising edges after the start-sampling edge: 3072 at defaults.
- DONE:
  - A/B/Sel hold the last vector.
  - Results hold until start, which restarts exactly as from IDLE.
- Input handling:
  - start is ignored in SETTLE and CHECK.
  - abort in SETTLE or CHECK:
    - Go to IDLE on the next edge; busy=0, done=0, pass=0, A/B/Sel=0.
    - err_count and first_fail_* retain their partial values.
  - abort has priority over start in all states; start+abort in IDLE/DONE stays or goes to IDLE.
  - abort in IDLE is a no-op; abort in DONE goes to IDLE and clears done and pass.
- dut_out is sampled only in CHECK; its value in any other state has no effect.

Test Plan:
1. Correct logic-unit model, defaults, one-cycle start pulse:
   - busy=1 for 3072 cycles.
   - Then done=1, pass=1, err_count=0, first_fail_valid=0.
2. Model with XNOR bit0 stuck at 0:
   - err_count=128, pass=0.
   - first_fail: Sel=11, A=0000, B=0000, got=1110.
3. dut_out tied to 0000:
   - 910 true mismatches; err_count saturates at 255.
   - first_fail: Sel=00, A=0001, B=0001, got=0000.
4. abort pulse 100 cycles after start:
   - Next edge: busy=0, done=0, A/B/Sel=0.
   - A new start then performs a full clean run identical to scenario 1.
5. rst_n low mid-sweep between clock edges:
   - All outputs 0 immediately.
   - After release, start runs a full sweep with pass=1.
6. start held high continuously:
   - Mid-sweep start is ignored (index increments normally).
   - On reaching DONE, a new sweep begins on the next edge with err_count cleared.
